// File: rtl/carrier_pkg.sv
// Shared types, default constants and the ROM content generator for the carrier NCO.
// The sine table is computed from a real-valued series at elaboration time.
package carrier_pkg;

    localparam int DEF_PHASE_W = 16;
    localparam int DEF_LUT_AW  = 6;
    localparam int DEF_OUT_W   = 10;
    localparam int DEF_AMP     = 399;
    localparam int DEF_FCW_RST = 328;

    typedef logic signed [DEF_OUT_W-1:0] sample_t;
    typedef logic [DEF_PHASE_W-1:0]      phase_t;

    typedef enum logic [1:0] {
        Q0 = 2'd0,
        Q1 = 2'd1,
        Q2 = 2'd2,
        Q3 = 2'd3
    } quad_e;

    // round(amp * sin((i + 0.5) * pi / 2^(aw+1))); the argument never exceeds pi/2,
    // so a short Taylor series is far more accurate than the output LSB
    function automatic int rom_entry(input int i, input int aw, input int amp);
        real x;
        real term;
        real s;
        x    = (real'(i) + 0.5) * 3.141592653589793 / real'(32'sd1 <<< (aw + 32'sd1));
        term = x;
        s    = x;
        for (int k = 1; k < 14; k++) begin
            term = -term * x * x / real'((32'sd2 * k) * (32'sd2 * k + 32'sd1));
            s    = s + term;
        end
        return $rtoi(real'(amp) * s + 0.5);
    endfunction

endpackage

// File: rtl/carrier_nco_qrom.sv
// Quarter-wave sine ROM with two independent registered read ports.
// Entries are unsigned magnitudes generated at elaboration from LUT_AW and AMP.
module carrier_nco_qrom
    import carrier_pkg::*;
#(
    parameter int LUT_AW = DEF_LUT_AW,
    parameter int OUT_W  = DEF_OUT_W,
    parameter int AMP    = DEF_AMP
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [LUT_AW-1:0] addr_a,
    input  logic [LUT_AW-1:0] addr_b,
    output logic [OUT_W-2:0]  data_a,
    output logic [OUT_W-2:0]  data_b
);

    localparam int DEPTH = 32'sd1 <<< LUT_AW;

    logic [OUT_W-2:0] rom_s [DEPTH];
    logic [OUT_W-2:0] data_a_r;
    logic [OUT_W-2:0] data_b_r;

    for (genvar g = 0; g < DEPTH; g++) begin : g_rom
        localparam int ROM_V = rom_entry(g, LUT_AW, AMP);
        assign rom_s[g] = ROM_V[OUT_W-2:0];
    end

    // registered read of both ports
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_a_r <= '0;
            data_b_r <= '0;
        end else begin
            data_a_r <= rom_s[addr_a];
            data_b_r <= rom_s[addr_b];
        end
    end

    assign data_a = data_a_r;
    assign data_b = data_b_r;

endmodule

// File: rtl/carrier_nco.sv
// Carrier NCO: phase accumulator with run-time retune, offset and clear, followed by a
// 3-stage quarter-wave lookup producing signed sine and cosine samples.
module carrier_nco
    import carrier_pkg::*;
#(
    parameter int PHASE_W = DEF_PHASE_W,
    parameter int LUT_AW  = DEF_LUT_AW,
    parameter int OUT_W   = DEF_OUT_W,
    parameter int AMP     = DEF_AMP,
    parameter int FCW_RST = DEF_FCW_RST
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               phase_clr,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [PHASE_W-1:0] cfg_fcw,
    input  logic               cfg_sync,
    input  logic [PHASE_W-1:0] phase_off,
    output logic               out_valid,
    output logic [OUT_W-1:0]   SinWave,
    output logic [OUT_W-1:0]   CosWave
);

    logic [PHASE_W-1:0] acc_r;
    logic [PHASE_W-1:0] fcw_r;
    logic [PHASE_W-1:0] pend_fcw_r;
    logic               pend_r;
    logic               cfg_ready_r;

    logic [PHASE_W-1:0] phase_s;
    logic [PHASE_W:0]   sum_s;
    logic               wrap_s;
    logic               accept_s;
    logic [PHASE_W-1:0] fcw_nxt_s;
    logic [PHASE_W-1:0] pend_fcw_nxt_s;
    logic               pend_nxt_s;

    logic               v1_r;
    quad_e              q1_r;
    logic [LUT_AW-1:0]  idx1_r;
    logic [LUT_AW-1:0]  nidx_s;
    logic               v2_r;
    quad_e              q2_r;
    logic [OUT_W-2:0]   rom_a_s;
    logic [OUT_W-2:0]   rom_b_s;

    logic [OUT_W-1:0]   pos_a_s;
    logic [OUT_W-1:0]   pos_b_s;
    logic [OUT_W-1:0]   neg_a_s;
    logic [OUT_W-1:0]   neg_b_s;
    logic [OUT_W-1:0]   sin_s;
    logic [OUT_W-1:0]   cos_s;
    logic               out_valid_r;
    logic [OUT_W-1:0]   sin_r;
    logic [OUT_W-1:0]   cos_r;

    // sample phase, accumulator sum and wrap detection
    always_comb begin
        phase_s  = acc_r + phase_off;
        sum_s    = {1'b0, acc_r} + {1'b0, fcw_r};
        wrap_s   = sum_s[PHASE_W];
        accept_s = cfg_valid & cfg_ready_r;
    end

    // retune control: a synced word waits for the next wrap or a clear
    always_comb begin
        fcw_nxt_s      = fcw_r;
        pend_nxt_s     = pend_r;
        pend_fcw_nxt_s = pend_fcw_r;
        if (accept_s) begin
            if (!cfg_sync || phase_clr) begin
                fcw_nxt_s = cfg_fcw;
            end else begin
                pend_nxt_s     = 1'b1;
                pend_fcw_nxt_s = cfg_fcw;
            end
        end else if (pend_r && (phase_clr || (en && wrap_s))) begin
            fcw_nxt_s  = pend_fcw_r;
            pend_nxt_s = 1'b0;
        end else begin
            fcw_nxt_s  = fcw_r;
            pend_nxt_s = pend_r;
        end
    end

    // accumulator and tuning registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_r       <= '0;
            fcw_r       <= PHASE_W'(FCW_RST);
            pend_fcw_r  <= '0;
            pend_r      <= 1'b0;
            cfg_ready_r <= 1'b1;
        end else begin
            if (phase_clr) begin
                acc_r <= '0;
            end else if (en) begin
                acc_r <= sum_s[PHASE_W-1:0];
            end else begin
                acc_r <= acc_r;
            end
            fcw_r       <= fcw_nxt_s;
            pend_fcw_r  <= pend_fcw_nxt_s;
            pend_r      <= pend_nxt_s;
            cfg_ready_r <= ~pend_nxt_s;
        end
    end

    // stage 1: fold the sample phase into quadrant and table index
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1_r   <= 1'b0;
            q1_r   <= Q0;
            idx1_r <= '0;
        end else begin
            v1_r <= en;
            if (en) begin
                q1_r   <= quad_e'(phase_s[PHASE_W-1 -: 2]);
                idx1_r <= phase_s[PHASE_W-3 -: LUT_AW];
            end
        end
    end

    assign nidx_s = ~idx1_r;

    carrier_nco_qrom #(
        .LUT_AW (LUT_AW),
        .OUT_W  (OUT_W),
        .AMP    (AMP)
    ) u_qrom (
        .clk    (clk),
        .rst    (rst),
        .addr_a (idx1_r),
        .addr_b (nidx_s),
        .data_a (rom_a_s),
        .data_b (rom_b_s)
    );

    // stage 2: carry quadrant and valid alongside the ROM read
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v2_r <= 1'b0;
            q2_r <= Q0;
        end else begin
            v2_r <= v1_r;
            q2_r <= q1_r;
        end
    end

    // stage 3 select: a = ROM[idx], b = ROM[~idx]
    always_comb begin
        pos_a_s = {1'b0, rom_a_s};
        pos_b_s = {1'b0, rom_b_s};
        neg_a_s = -pos_a_s;
        neg_b_s = -pos_b_s;
        sin_s   = pos_a_s;
        cos_s   = pos_b_s;
        case (q2_r)
            Q0: begin sin_s = pos_a_s; cos_s = pos_b_s; end
            Q1: begin sin_s = pos_b_s; cos_s = neg_a_s; end
            Q2: begin sin_s = neg_a_s; cos_s = neg_b_s; end
            Q3: begin sin_s = neg_b_s; cos_s = pos_a_s; end
            default: begin sin_s = pos_a_s; cos_s = pos_b_s; end
        endcase
    end

    // stage 3: output registers hold their value between samples
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_r <= 1'b0;
            sin_r       <= '0;
            cos_r       <= '0;
        end else begin
            out_valid_r <= v2_r;
            if (v2_r) begin
                sin_r <= sin_s;
                cos_r <= cos_s;
            end
        end
    end

    assign cfg_ready = cfg_ready_r;
    assign out_valid = out_valid_r;
    assign SinWave   = sin_r;
    assign CosWave   = cos_r;

endmodule

// File: doc/carrier_nco.md
# carrier_nco

Parametrised numerically-controlled oscillator that produces signed, two's-complement sine and cosine carrier samples for the modulator datapath. It is the next generation of the fixed 200-step carrier generator: it adds a run-time tuning word, phase offset, enable, phase clear and phase-continuous retune. Sine and cosine come from a shared quarter-wave ROM through a 3-stage pipeline.

## Interface
- PHASE_W, 16: phase accumulator width; must be at least LUT_AW+2
- LUT_AW, 6: quarter-wave ROM address width (2^LUT_AW entries)
- OUT_W, 10: output sample width, signed
- AMP, 399: peak amplitude; must not exceed 2^(OUT_W-1)-1
- FCW_RST, 328: tuning word loaded at reset

- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-low reset
- en  in  1  advance accumulator and issue one sample this cycle
- phase_clr  in  1  synchronous accumulator clear
- cfg_valid  in  1  tuning-word update request
- cfg_ready  out  1  update can be accepted
- cfg_fcw  in  PHASE_W  new frequency control word
- cfg_sync  in  1  1 = apply at next phase wrap; 0 = apply immediately
- phase_off  in  PHASE_W  phase offset, sampled every en cycle
- out_valid  out  1  SinWave/CosWave carry a new sample
- SinWave  out  OUT_W  signed sine sample
- CosWave  out  OUT_W  signed cosine sample

## Operation
- Reset (rst low, asynchronous):
  - acc=0, fcw=FCW_RST, no pending retune
  - cfg_ready=1, out_valid=0, SinWave=0, CosWave=0
  - all pipeline valids=0
- Accumulator:
  - When en=1: sample phase p=acc+phase_off (mod 2^PHASE_W), then acc<=acc+fcw (mod 2^PHASE_W).
  - A wrap is a carry out of that add.
- phase_clr=1: acc<=0 next cycle. This overrides the en increment, but the en cycle still issues a sample with the pre-clear phase.
- Retune handshake (transfer on cfg_valid && cfg_ready):
  - cfg_sync=0: fcw<=cfg_fcw next cycle; cfg_ready stays 1.
  - cfg_sync=1: cfg_fcw is held pending and cfg_ready=0. The pending word is applied on the first en cycle whose add wraps, with the new fcw used from the following add. It is also applied on phase_clr. cfg_ready returns to 1 the cycle after application.
  - Accept and phase_clr in the same cycle: the word is applied with the clear; no pending state.
- Lookup:
  - q=p[PHASE_W-1:PHASE_W-2]; idx=p[PHASE_W-3 -: LUT_AW] (truncated, no rounding); nidx=~idx.
  - ROM[i]=round(AMP·sin((i+0.5)·π/2^(LUT_AW+1))), unsigned, half-LSB offset. This gives exact symmetry and no duplicated endpoints.
  - Sine by quadrant: q0 +ROM[idx]; q1 +ROM[nidx]; q2 −ROM[idx]; q3 −ROM[nidx].
  - Cosine by quadrant: q0 +ROM[nidx]; q1 −ROM[idx]; q2 −ROM[nidx]; q3 +ROM[idx].
  - Negation is two's complement at OUT_W; |result| ≤ AMP, so it never overflows.

## Timing
- Stage 1: register p, q, idx, and the sample's valid.
- Stage 2: registered ROM reads (two ports).
- Stage 3: sign apply into the output registers.
- Latency: en high at the edge of cycle n → out_valid=1 with that sample's values after the edge of cycle n+3.
- One sample per cycle at full rate.
- out_valid=0 cycles hold the previous SinWave/CosWave values.
- phase_off and phase_clr have no effect on samples already in flight.
- Reset mid-operation flushes the pipeline immediately; the first valid appears 3 cycles after the first en following reset release.

## Structure
- Shared package carrier_pkg holds:
  - default constants for PHASE_W, LUT_AW, OUT_W, AMP
  - a typedef for the signed sample (OUT_W)
  - a typedef for the phase word (PHASE_W)
  - the quadrant enum Q0..Q3
- One sub-module, carrier_nco_qrom: dual-read-port, registered-output quarter-wave ROM, contents generated at elaboration from LUT_AW and AMP.
- Top level contains the accumulator, retune control, address fold and sign stage.

## Test plan
- Reset hold: rst low with en toggling → out_valid=0, SinWave=CosWave=0, cfg_ready=1. After release with fcw=FCW_RST, the first out_valid arrives 3 cycles after the first en.
- Quadrant steps: defaults, sync retune to cfg_fcw=16384 then phase_clr, en continuously. Consecutive (Sin,Cos) = (5,399), (399,−5), (−5,−399), (−399,5), repeating.
- Phase offset: fcw=0, phase_off=32768 → SinWave=−5, CosWave=−399 held. Then phase_off=16384 → SinWave=399, CosWave=−5, three cycles later.
- Sync retune: fcw=4096; accept cfg_fcw=8192 with cfg_sync=1 mid-period.
  - cfg_ready=0 until wrap.
  - Sample spacing changes exactly after the wrap.
  - A second cfg_valid is not accepted while pending.
- Enable gaps and async reset: random en pattern → output sample count equals en count, values hold when out_valid=0. Assert rst for one cycle mid-stream → outputs zero asynchronously, acc=0, fcw=FCW_RST.
